// File: rtl/rec_time_counter.sv
// rec_time_counter: elapsed-seconds timer for the record/playback path.
// Counts whole seconds while running and drives the 6-bit time code for the
// two-digit seven-segment display. BLANK_CODE blanks the display while idle.
//
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous reset, active-low
//   i_start    1-cycle pulse: start from 0 / resume from pause
//   i_pause    1-cycle pulse: toggles run <-> pause
//   i_stop     1-cycle pulse: abort to idle
//   i_speed    count rate = i_speed+1 seconds per real second
//   o_time     seconds elapsed, or BLANK_CODE when idle
//   o_state    0 idle, 1 run, 2 pause, 3 done
//   o_running  high only while running
//   o_done     1-cycle pulse when the count reaches MAX_SEC
module rec_time_counter #(
    parameter int unsigned CLK_FREQ   = 12_000_000,
    parameter int unsigned MAX_SEC    = 32,
    parameter int unsigned BLANK_CODE = 63
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_stop,
    input  logic [2:0] i_speed,
    output logic [5:0] o_time,
    output logic [1:0] o_state,
    output logic       o_running,
    output logic       o_done
);

    // Prescaler must hold CLK_FREQ-1 plus the largest step (8) before wrap.
    localparam int unsigned PW = $clog2(CLK_FREQ + 8);
    localparam logic [PW-1:0] FreqW  = PW'(CLK_FREQ);
    localparam logic [5:0]    MaxW   = 6'(MAX_SEC);
    localparam logic [5:0]    BlankW = 6'(BLANK_CODE);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [5:0]    sec_q, sec_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [PW-1:0] sum;
    logic [5:0]    time_q, time_d;
    logic          done_q, done_d;
    logic          run_q, run_d;

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
        sum     = pre_q + PW'(i_speed) + PW'(1);

        if (i_stop) begin
            state_d = StIdle;
            sec_d   = '0;
            pre_d   = '0;
        end else if (i_start) begin
            state_d = StRun;
            // Start from pause resumes; from anywhere else it restarts at zero.
            if (state_q != StPause) begin
                sec_d = '0;
                pre_d = '0;
            end
        end else if (i_pause && state_q == StRun) begin
            state_d = StPause;
        end else if (i_pause && state_q == StPause) begin
            state_d = StRun;
        end else if (state_q == StRun) begin
            if (sum >= FreqW) begin
                // Keep the remainder so fractional steps never drift.
                pre_d = sum - FreqW;
                sec_d = sec_q + 6'd1;
                if (sec_d == MaxW) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end else begin
                pre_d = sum;
            end
        end

        time_d = (state_d == StIdle) ? BlankW : sec_d;
        run_d  = (state_d == StRun);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            sec_q   <= '0;
            pre_q   <= '0;
            time_q  <= BlankW;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            pre_q   <= pre_d;
            time_q  <= time_d;
            done_q  <= done_d;
            run_q   <= run_d;
        end
    end

    assign o_time    = time_q;
    assign o_state   = state_q;
    assign o_running = run_q;
    assign o_done    = done_q;

endmodule
